// File: rtl/arb_mux_if.sv
// arb_mux_if: producer-side and consumer-side handshake bundle for arb_mux
interface arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);
  logic [NCH-1:0] in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic out_ready;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: round-robin N-channel arbitrating mux with a registered valid/ready output stage
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH = 4
) (
  input logic clk,
  input logic reset_n,
  arb_mux_if.slave bus
);
  localparam int CW = $clog2(NCH);
  logic [CW-1:0] last, gidx, out_ch;
  logic [NCH-1:0] grant;
  logic hit, load, out_valid;
  logic [WIDTH-1:0] out_data;
  assign load = !out_valid || bus.out_ready;
  assign bus.in_ready = (reset_n && load) ? grant : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_ch = out_ch;
  // rotating-priority search: first valid channel strictly after the last one granted
  always_comb begin
    grant = '0;
    gidx = '0;
    hit = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (!hit && bus.in_valid[(int'(last) + k) % NCH]) begin
        hit = 1'b1;
        gidx = CW'((int'(last) + k) % NCH);
        grant[gidx] = 1'b1;
      end
    end
  end
  // output register refills whenever it is empty or draining; pointer advances only on a transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      last <= CW'(NCH - 1);
    end else if (load) begin
      out_valid <= hit;
      if (hit) begin
        out_data <= bus.in_data[int'(gidx) * WIDTH +: WIDTH];
        out_ch <= gidx;
        last <= gidx;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed stimulus with a queue scoreboard checked by an output monitor
module tb_arb_mux;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [1:0] ch;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  arb_mux_if #(.WIDTH(32), .NCH(4)) bus ();
  arb_mux #(.WIDTH(32), .NCH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int i, input logic [31:0] d);
    bus.in_data[i*32 +: 32] = d;
  endtask
  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    q.push_back('{ch: ch, d: d});
  endtask
  // a handshake completes at the next rising edge: pop the expected word and compare
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=ch%0d/%h required=none", bus.out_ch, bus.out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_out_ch", 32'(bus.out_ch), 32'(e.ch));
        chk("sb_out_data", bus.out_data, e.d);
      end
    end
  end
  initial begin
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i));
    repeat (3) step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
    for (int i = 0; i < 8; i++) push(2'(i % 4), 32'hA0 + 32'(i % 4));
    reset_n = 1'b1;
    #1;
    chk("first_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    chk("first_out_ch", 32'(bus.out_ch), 32'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("rr_no_gap", 32'(bus.out_valid), 32'h1);
      chk("rr_out_ch", 32'(bus.out_ch), 32'(i % 4));
    end
    bus.in_valid = 4'b0100;
    set_ch(2, 32'hDEAD_BEEF);
    push(2'd2, 32'hDEAD_BEEF);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b1111;
    set_ch(2, 32'hA2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_out_data", bus.out_data, 32'hDEAD_BEEF);
      chk("bp_out_ch", 32'(bus.out_ch), 32'h2);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(bus.in_ready), 32'b1000);
    push(2'd3, 32'hA3);
    step();
    bus.in_valid = 4'b1000;
    #1;
    chk("lone_ch3_grant", 32'(bus.in_ready), 32'b1000);
    push(2'd3, 32'hA3);
    step();
    bus.in_valid = 4'b0010;
    #1;
    chk("sparse_ch1_grant", 32'(bus.in_ready), 32'b0010);
    push(2'd1, 32'hA1);
    step();
    chk("sparse_no_bubble", 32'(bus.out_valid), 32'h1);
    bus.in_valid = 4'b1111;
    #1;
    chk("wrap_grant_ch2", 32'(bus.in_ready), 32'b0100);
    push(2'd2, 32'hA2);
    step();
    bus.in_valid = 4'b0000;
    step();
    chk("idle_out_valid", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 4'b0001;
    set_ch(0, 32'h1234_5678);
    push(2'd0, 32'h1234_5678);
    step();
    bus.in_valid = 4'b0000;
    chk("drain_valid_once", 32'(bus.out_valid), 32'h1);
    step();
    chk("drain_empty", 32'(bus.out_valid), 32'h0);
    chk("drain_data_kept", bus.out_data, 32'h1234_5678);
    step();
    chk("drain_stays_empty", 32'(bus.out_valid), 32'h0);
    set_ch(0, 32'hA0);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0100;
    set_ch(2, 32'h5A5A_0002);
    step();
    bus.in_valid = 4'b0000;
    chk("pre_reset_held", 32'(bus.out_valid), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_data", bus.out_data, 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_word", 32'(bus.out_valid), 32'h0);
    end
    chk("sb_queue_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel round-robin arbitrating multiplexer with a registered valid/ready output stage, the sequential successor to the fixed 4:1 select mux. It merges up to NCH producer streams, such as monitor/debug request sources and memory-side requesters, onto one consumer port. Selection comes from a fair rotating-priority arbiter instead of an external select. Each accepted word is held in an output register until the consumer takes it.

## Interface
- WIDTH, 32, data width of each channel in bits.
- NCH, 4, number of input channels; legal range 2..16.
- CW, $clog2(NCH), derived channel-index width; not to be overridden.

- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- in_valid  input  NCH  bit i: channel i presents a word.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  bit i: channel i's word is accepted this cycle; at most one bit high (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_ch  output  CW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- Load condition: load = !out_valid || out_ready. The output register may be refilled in the same cycle it drains.
- Arbitration (combinational): starting from channel (last+1) mod NCH and rotating upward with wrap, grant the first channel with in_valid high.
  - No valid channel means no grant.
- in_ready[i] = load && grant[i]. in_ready never depends on in_valid of the granted channel beyond the arbitration itself.
- Transfer on a channel happens when in_valid[i] && in_ready[i].
  - On a transfer: out_data <= in_data[i], out_ch <= i, out_valid <= 1, last <= i.
- On a load with no grant: out_valid <= 0 if out_ready was high. If out_valid was already 0 it stays 0. out_data and out_ch hold their previous values.
- When !load (out_valid && !out_ready): out_valid, out_data and out_ch hold, all in_ready are low, and last holds.
- Fairness: the pointer moves only on a transfer. A channel that stays valid is granted within NCH transfers.
- A lone requester is granted every load cycle, with no bubble.
- in_valid falling without a transfer is legal. The arbiter re-evaluates each cycle and keeps no sticky grant.

## Timing
- Reset values while reset_n is low, asynchronous:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - last = NCH-1, so channel 0 has the highest priority after reset.
  - in_ready = 0 because in_valid is ignored until reset is released.
- Reset asserted mid-operation discards a held word with no handshake. The first cycle after release behaves as post-reset.
- Latency: 1 cycle. A word transferred in cycle t appears on out_data/out_valid in cycle t+1.
- Throughput: 1 word/cycle while out_ready stays high.
- Simultaneous drain and refill in the same cycle: out_valid stays 1 and data changes to the new word. No bubble, no duplication.
- Backpressure: out_valid && !out_ready freezes all state. No input is accepted.
- Pointer wrap: after a grant to NCH-1, the search starts at channel 0.
- in_ready is combinational from in_valid, out_valid, out_ready and last. There is no combinational path from in_data to any output.

## Test plan
- Reset and idle (NCH=4, WIDTH=32): hold reset_n low 3 cycles with in_valid=4'b1111. Required: in_ready=0, out_valid=0, out_data=0, out_ch=0. After release with out_ready=1, the first transfer is ch0 and out_ch=0 on the next cycle.
- Round-robin fairness: all 4 channels valid continuously, with ch i data = 32'hA0+i and out_ready=1. Required: out_ch sequence 0,1,2,3,0,1… with out_valid high every cycle and no gaps.
- Backpressure hold: out_ready=0 for 5 cycles while out_valid=1 with ch2's 32'hDEAD_BEEF held. Required: out_data/out_ch stable, in_ready=0 throughout. On out_ready=1, the next channel granted is ch3.
- Sparse and wrap: only ch3 valid, then only ch1 valid. Required: ch3 granted, then ch1 granted with no bubble. The pointer wraps, so a later all-valid request grants ch2 first.
- Drain to empty: single word from ch0, then in_valid=0 with out_ready=1. Required: out_valid 1 for exactly one cycle, then 0. out_data retains the last value.
- Async reset mid-stream: assert reset_n low between clock edges while out_valid=1. Required: out_valid falls immediately without waiting for an edge. After release, the held word is never presented.
